// File: rtl/adma_desc_fetch_if.sv
// Descriptor fetch bus bundle: system RAM read port plus the descriptor
// valid/ready handshake toward the consumer.
interface adma_desc_fetch_if;
  logic [63:0] ram_address;
  logic        ram_read;
  logic        ram_write;
  logic [31:0] ram_rdata;
  logic        desc_valid;
  logic        desc_ready;
  logic [16:0] desc_len;
  logic [31:0] desc_addr;
  logic        desc_end;
  logic        desc_int;

  // Fetch engine side
  modport master (
    output ram_address,
    output ram_read,
    output ram_write,
    input  ram_rdata,
    output desc_valid,
    input  desc_ready,
    output desc_len,
    output desc_addr,
    output desc_end,
    output desc_int
  );

  // RAM and descriptor consumer side
  modport slave (
    input  ram_address,
    input  ram_read,
    input  ram_write,
    output ram_rdata,
    input  desc_valid,
    output desc_ready,
    input  desc_len,
    input  desc_addr,
    input  desc_end,
    input  desc_int
  );
endinterface

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetch engine. Walks a chain of 64-bit descriptors in system
// RAM, follows link descriptors, skips nops and presents transfer descriptors
// to a consumer over a valid/ready handshake.
module adma_desc_fetch (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       desc_base_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       desc_count,
  adma_desc_fetch_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StCap1,
    StPresent,
    StError
  } state_e;

  localparam logic [1:0] ActTran = 2'b10;
  localparam logic [1:0] ActLink = 2'b11;

  state_e      state_q, state_d;
  logic [63:0] cur_addr_q, cur_addr_d;
  logic [63:0] ram_addr_q, ram_addr_c;
  logic        ram_read_c;

  // Only the decoded fields of word0 are kept; the remaining bits are reserved.
  logic        w0_valid_q, w0_valid_d;
  logic        w0_end_q, w0_end_d;
  logic        w0_int_q, w0_int_d;
  logic [1:0]  w0_act_q, w0_act_d;
  logic [15:0] w0_len_q, w0_len_d;

  logic [16:0] desc_len_q, desc_len_d;
  logic [31:0] desc_addr_q, desc_addr_d;
  logic        desc_end_q, desc_end_d;
  logic        desc_int_q, desc_int_d;

  logic [15:0] count_q, count_d;
  logic        error_q, error_d;
  logic        done_q, done_d;

  logic [16:0] len_bytes;
  logic [31:0] word1;
  logic        base_aligned;

  // Length field of zero encodes the maximum 64 KiB transfer.
  assign len_bytes    = (w0_len_q == 16'h0) ? 17'h1_0000 : {1'b0, w0_len_q};
  assign word1        = bus.ram_rdata;
  assign base_aligned = (desc_base_addr[2:0] == 3'b000);

  // RAM read strobe and address; the address holds its last value between reads.
  always_comb begin
    ram_read_c = 1'b0;
    ram_addr_c = ram_addr_q;
    case (state_q)
      StRd0: begin
        ram_read_c = 1'b1;
        ram_addr_c = cur_addr_q;
      end
      StRd1: begin
        ram_read_c = 1'b1;
        ram_addr_c = cur_addr_q + 64'd4;
      end
      default: ;
    endcase
  end

  // Next-state logic: walk control, word capture, decode and status.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    w0_valid_d  = w0_valid_q;
    w0_end_d    = w0_end_q;
    w0_int_d    = w0_int_q;
    w0_act_d    = w0_act_q;
    w0_len_d    = w0_len_q;
    desc_len_d  = desc_len_q;
    desc_addr_d = desc_addr_q;
    desc_end_d  = desc_end_q;
    desc_int_d  = desc_int_q;
    count_d     = count_q;
    error_d     = error_q;
    done_d      = 1'b0;

    case (state_q)
      // Start is honoured only when not walking; a misaligned base errors out
      // before any RAM access.
      StIdle, StError: begin
        if (start) begin
          count_d = 16'h0;
          if (base_aligned) begin
            error_d    = 1'b0;
            cur_addr_d = desc_base_addr;
            state_d    = StRd0;
          end else begin
            error_d = 1'b1;
            state_d = StError;
          end
        end
      end

      StRd0: begin
        state_d = StRd1;
      end

      StRd1: begin
        w0_valid_d = bus.ram_rdata[0];
        w0_end_d   = bus.ram_rdata[1];
        w0_int_d   = bus.ram_rdata[2];
        w0_act_d   = bus.ram_rdata[5:4];
        w0_len_d   = bus.ram_rdata[31:16];
        state_d    = StCap1;
      end

      // word1 is on ram_rdata this cycle and is decoded without a register.
      StCap1: begin
        count_d = count_q + 16'd1;
        if (!w0_valid_q) begin
          error_d = 1'b1;
          state_d = StError;
        end else begin
          case (w0_act_q)
            ActTran: begin
              desc_len_d  = len_bytes;
              desc_addr_d = word1;
              desc_end_d  = w0_end_q;
              desc_int_d  = w0_int_q;
              state_d     = StPresent;
            end
            // The end bit of a link descriptor is ignored.
            ActLink: begin
              if (word1[2:0] != 3'b000) begin
                error_d = 1'b1;
                state_d = StError;
              end else begin
                cur_addr_d = {32'h0, word1};
                state_d    = StRd0;
              end
            end
            default: begin
              if (w0_end_q) begin
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                cur_addr_d = cur_addr_q + 64'd8;
                state_d    = StRd0;
              end
            end
          endcase
        end
      end

      StPresent: begin
        if (bus.desc_ready) begin
          if (desc_end_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cur_addr_d = cur_addr_q + 64'd8;
            state_d    = StRd0;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything and leaves status and presented fields untouched.
    if (abort) begin
      state_d     = StIdle;
      done_d      = 1'b0;
      error_d     = error_q;
      count_d     = count_q;
      cur_addr_d  = cur_addr_q;
      desc_len_d  = desc_len_q;
      desc_addr_d = desc_addr_q;
      desc_end_d  = desc_end_q;
      desc_int_d  = desc_int_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      cur_addr_q  <= 64'h0;
      ram_addr_q  <= 64'h0;
      w0_valid_q  <= 1'b0;
      w0_end_q    <= 1'b0;
      w0_int_q    <= 1'b0;
      w0_act_q    <= 2'b00;
      w0_len_q    <= 16'h0;
      desc_len_q  <= 17'h0;
      desc_addr_q <= 32'h0;
      desc_end_q  <= 1'b0;
      desc_int_q  <= 1'b0;
      count_q     <= 16'h0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      ram_addr_q  <= ram_addr_c;
      w0_valid_q  <= w0_valid_d;
      w0_end_q    <= w0_end_d;
      w0_int_q    <= w0_int_d;
      w0_act_q    <= w0_act_d;
      w0_len_q    <= w0_len_d;
      desc_len_q  <= desc_len_d;
      desc_addr_q <= desc_addr_d;
      desc_end_q  <= desc_end_d;
      desc_int_q  <= desc_int_d;
      count_q     <= count_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  assign bus.ram_read    = ram_read_c;
  assign bus.ram_address = ram_addr_c;
  assign bus.ram_write   = 1'b0;
  assign bus.desc_valid  = (state_q == StPresent);
  assign bus.desc_len    = desc_len_q;
  assign bus.desc_addr   = desc_addr_q;
  assign bus.desc_end    = desc_end_q;
  assign bus.desc_int    = desc_int_q;

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign error      = error_q;
  assign desc_count = count_q;

endmodule
